// File: rtl/wisc_pkg.sv
// Shared WISC definitions: instruction encodings, fetch FSM state codes,
// fetch-unit default vectors and the accept-qualifier bundle for next-PC selection.
package wisc_pkg;

  localparam logic [15:0] NopInstr = 16'h0800;

  localparam logic [4:0] OpHalt = 5'b00000;
  localparam logic [4:0] OpNop  = 5'b00001;
  localparam logic [4:0] OpSiic = 5'b00010;
  localparam logic [4:0] OpRti  = 5'b00011;

  localparam logic [15:0] DefaultResetPc   = 16'h0000;
  localparam logic [15:0] DefaultExcVector = 16'h0002;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t StFetch  = 2'd0;
  localparam fetch_state_t StHold   = 2'd1;
  localparam fetch_state_t StHalted = 2'd2;

  // Control-flow outcomes, already qualified by the accept handshake.
  typedef struct packed {
    logic halt;
    logic siic;
    logic rti;
    logic redirect;
  } fetch_acc_t;

  function automatic logic [15:0] pc_align(input logic [15:0] pc);
    return {pc[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side handshake signals of the fetch stage.
interface fetch_unit_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;

  logic [15:0] instr;
  logic [15:0] pc_inc;
  logic        instr_valid;
  logic        id_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        siic;
  logic        rti;
  logic        halted;
  logic [15:0] epc;

  modport master (
    output imem_req, imem_addr, instr, pc_inc, instr_valid, halted, epc,
    input  imem_rdata, imem_done, id_ready, redirect, redirect_pc, halt, siic, rti
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc_inc, instr_valid, halted, epc,
    output imem_rdata, imem_done, id_ready, redirect, redirect_pc, halt, siic, rti
  );

endinterface

// File: rtl/fetch_unit_pc_sel.sv
// Next-PC priority mux applied when decode accepts the held instruction.
module fetch_pc_sel
  import wisc_pkg::*;
(
  input  fetch_acc_t  acc_i,
  input  logic [15:0] pc_i,
  input  logic [15:0] epc_i,
  input  logic [15:0] redirect_pc_i,
  input  logic [15:0] exc_vector_i,
  output logic [15:0] next_pc_o
);

  logic [15:0] sel_pc;

  always_comb begin
    sel_pc = pc_i;
    if (acc_i.halt) begin
      sel_pc = pc_i;
    end else if (acc_i.siic) begin
      sel_pc = exc_vector_i;
    end else if (acc_i.rti) begin
      sel_pc = epc_i;
    end else if (acc_i.redirect) begin
      sel_pc = redirect_pc_i;
    end
  end

  assign next_pc_o = pc_align(sel_pc);

endmodule

// File: rtl/fetch_unit.sv
// WISC instruction fetch stage: owns the PC, runs one imem read at a time and
// holds the fetched instruction until decode accepts it.
module fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = DefaultResetPc,
  parameter logic [15:0] EXC_VECTOR = DefaultExcVector
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  epc_q, epc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  pc_inc_q, pc_inc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         halted_q, halted_d;

  logic         accept;
  fetch_acc_t   acc;
  logic [15:0]  sel_pc;
  logic [15:0]  pc_plus2;

  assign accept   = (state_q == StHold) && instr_valid_q && bus.id_ready;
  assign pc_plus2 = pc_q + 16'd2;

  // Outcome flags only matter on the accept cycle.
  assign acc.halt     = accept & bus.halt;
  assign acc.siic     = accept & bus.siic;
  assign acc.rti      = accept & bus.rti;
  assign acc.redirect = accept & bus.redirect;

  fetch_pc_sel u_pc_sel (
    .acc_i         (acc),
    .pc_i          (pc_q),
    .epc_i         (epc_q),
    .redirect_pc_i (bus.redirect_pc),
    .exc_vector_i  (EXC_VECTOR),
    .next_pc_o     (sel_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    instr_d       = instr_q;
    pc_inc_d      = pc_inc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;

    case (state_q)
      StFetch: begin
        if (bus.imem_done) begin
          instr_d       = bus.imem_rdata;
          pc_inc_d      = pc_plus2;
          pc_d          = pc_plus2;
          instr_valid_d = 1'b1;
          state_d       = StHold;
        end
      end
      StHold: begin
        if (accept) begin
          instr_valid_d = 1'b0;
          if (acc.halt) begin
            halted_d = 1'b1;
            state_d  = StHalted;
          end else begin
            if (acc.siic) begin
              epc_d = pc_inc_q;
            end
            pc_d    = sel_pc;
            state_d = StFetch;
          end
        end
      end
      default: begin
        // Halted: only reset leaves this state.
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFetch;
      pc_q          <= pc_align(RESET_PC);
      epc_q         <= 16'h0000;
      instr_q       <= NopInstr;
      pc_inc_q      <= 16'h0000;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      instr_q       <= instr_d;
      pc_inc_q      <= pc_inc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  // Gated by rst_n so a read in flight is dropped the instant reset asserts.
  assign bus.imem_req    = rst_n && (state_q == StFetch);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.pc_inc      = pc_inc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = halted_q;
  assign bus.epc         = epc_q;

endmodule
